// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the IF stage: fetch FSM states, reset/exception
// vectors and the 9-bit exception codes carried down the pipe.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'hbfc0_0380;

  localparam logic [8:0] EXC_NONE = 9'h000;
  localparam logic [8:0] ADEL_IF  = 9'b0_1000_0000;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch PC priority mux: exception vector, eret target, branch
// target after the delay slot, sequential +4, otherwise hold.
module fetch_next_pc #(
  parameter logic [31:0] EXC_VEC = 32'hbfc0_0380
) (
  input  logic [31:0] fetch_pc_i,
  input  logic        exc_flush_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        deliver_i,
  input  logic        br_pend_i,
  input  logic [31:0] br_pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] next_pc_o
);

  always_comb begin
    next_pc_o = fetch_pc_i;
    if (exc_flush_i) begin
      next_pc_o = EXC_VEC;
    end else if (eret_i) begin
      next_pc_o = epc_i;
    end else if (deliver_i && br_pend_i) begin
      next_pc_o = br_pc_i;
    end else if (deliver_i && br_taken_i) begin
      next_pc_o = br_target_i;
    end else if (deliver_i) begin
      next_pc_o = fetch_pc_i + 32'd4;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS IF-stage front end: owns the fetch PC, runs the instruction-memory
// handshake and hands {pc, inst, except} to ID. Optional IF_PERF_CNT_EN.
module pc_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] fetch_pc_o,
  input  logic [31:0] det_realpc_i,
  input  logic        det_ok_i,
  input  logic [8:0]  det_except_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_flush_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        id_allowin_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic [8:0]  if_except_o,
  output logic [31:0] perf_wait_cyc_o,
  output logic [31:0] perf_discard_o
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q, if_pc_q, if_inst_q, br_pc_q, next_pc_d;
  logic [8:0]   if_except_q;
  logic         if_valid_q, inst_req_q, discard_q, br_pend_q;
  logic         redirect, slot_free, resp, deliver;

  assign redirect  = exc_flush_i | eret_i;
  assign slot_free = !if_valid_q || id_allowin_i;
  assign resp      = (state_q == WAIT) && inst_data_ok_i;
  // A response that collides with a redirect is dropped on the spot.
  assign deliver   = resp && !discard_q && !redirect;

  fetch_next_pc #(.EXC_VEC(EXC_VEC)) u_next_pc (
    .fetch_pc_i  (fetch_pc_q),
    .exc_flush_i (exc_flush_i),
    .eret_i      (eret_i),
    .epc_i       (epc_i),
    .deliver_i   (deliver),
    .br_pend_i   (br_pend_q),
    .br_pc_i     (br_pc_q),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .next_pc_o   (next_pc_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      inst_req_q  <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      if_except_q <= EXC_NONE;
      discard_q   <= 1'b0;
      br_pend_q   <= 1'b0;
      br_pc_q     <= 32'h0;
    end else begin
      fetch_pc_q <= next_pc_d;

      if (redirect) begin
        br_pend_q <= 1'b0;
      end else if (deliver) begin
        br_pend_q <= br_pend_q & br_taken_i;
        if (br_pend_q && br_taken_i) br_pc_q <= br_target_i;
      end else if (br_taken_i) begin
        br_pend_q <= 1'b1;
        br_pc_q   <= br_target_i;
      end

      if (redirect) begin
        if_valid_q <= 1'b0;
      end else if (deliver) begin
        if_valid_q  <= 1'b1;
        if_pc_q     <= fetch_pc_q;
        if_inst_q   <= inst_rdata_i;
        if_except_q <= EXC_NONE;
      end else if (state_q == IDLE && slot_free && !det_ok_i) begin
        if_valid_q  <= 1'b1;
        if_pc_q     <= fetch_pc_q;
        if_inst_q   <= 32'h0;
        if_except_q <= det_except_i;
      end else if (id_allowin_i) begin
        if_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!redirect && slot_free && det_ok_i) begin
            state_q    <= REQ;
            inst_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (redirect) discard_q <= 1'b1;
          if (inst_addr_ok_i) begin
            state_q    <= WAIT;
            inst_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (inst_data_ok_i) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
          end else if (redirect) begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          inst_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_wait_q, perf_discard_q;
  logic        drop;

  assign drop = resp && (discard_q || redirect);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_wait_q    <= 32'h0;
      perf_discard_q <= 32'h0;
    end else begin
      if (state_q != IDLE) perf_wait_q <= sat_inc(perf_wait_q);
      if (drop)            perf_discard_q <= sat_inc(perf_discard_q);
    end
  end

  assign perf_wait_cyc_o = perf_wait_q;
  assign perf_discard_o  = perf_discard_q;
`else
  assign perf_wait_cyc_o = 32'h0;
  assign perf_discard_o  = 32'h0;
`endif

  assign fetch_pc_o  = fetch_pc_q;
  assign inst_req_o  = inst_req_q;
  assign inst_addr_o = det_realpc_i;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_except_o = if_except_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- IF-stage front end of the MIPS pipeline. Owns the architectural fetch PC.
- Drives the PC to the downstream PC exception detector and receives back the translated address, an address-OK flag and an exception code.
- Issues instruction-memory requests over an addr_ok/data_ok handshake, handles branch delay-slot redirects and exception/eret flushes, and hands {pc, inst, except} to ID.

Parameters:
- RESET_PC, 32'hbfc0_0000, PC value after reset.
- EXC_VEC, 32'hbfc0_0380, redirect target on exc_flush.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_pc  out  32  current PC, sent to the exception detector
- det_realpc  in  32  translated address from the detector
- det_ok  in  1  1 = PC aligned, fetch permitted
- det_except  in  9  exception code from the detector
- inst_req  out  1  memory request valid
- inst_addr  out  32  equals det_realpc
- inst_addr_ok  in  1  memory accepted the request
- inst_data_ok  in  1  instruction data returned
- inst_rdata  in  32  instruction word
- br_taken  in  1  branch resolved taken in ID (1-cycle pulse)
- br_target  in  32  branch target
- exc_flush  in  1  exception commit (pulse)
- eret  in  1  eret commit (pulse)
- epc  in  32  eret target
- id_allowin  in  1  ID can accept this cycle
- if_valid  out  1  IF output valid
- if_pc  out  32  PC of the delivered instruction
- if_inst  out  32  delivered instruction (0 for an exception bubble)
- if_except  out  9  exception code carried with the instruction
- perf_wait_cyc  out  32  wait-cycle count (IF_PERF_CNT_EN)
- perf_discard  out  32  discard count (IF_PERF_CNT_EN)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - fetch_pc=RESET_PC, state=IDLE
  - inst_req=0, if_valid=0, if_pc=0, if_inst=0, if_except=0
  - discard=0, br_pend=0, br_pc=0, both perf counters 0
- Reset mid-transaction: state drops to IDLE. A late inst_data_ok after reset is ignored, because only the WAIT state accepts data.
- FSM, three states:
  - IDLE: a slot is free when !if_valid or id_allowin.
    - Slot free, no redirect this cycle, det_ok=1 → REQ.
    - Slot free, no redirect, det_ok=0 → load a bubble: if_valid=1, if_pc=fetch_pc, if_inst=0, if_except=det_except. No memory request. Stay IDLE; fetch_pc is not advanced, so the unit waits for a flush.
  - REQ: inst_req=1, inst_addr=det_realpc. inst_req is held until inst_addr_ok and is never withdrawn. On inst_addr_ok → WAIT.
  - WAIT: on inst_data_ok → IDLE.
    - If discard=1: drop the data and clear discard.
    - Else: if_valid=1, if_pc=fetch_pc, if_inst=inst_rdata, if_except=0, and fetch_pc advances (see below).
- fetch_pc is frozen from REQ entry until the response, so if_pc matches the fetched address.
- if_valid clears on id_allowin when no new instruction is loaded that cycle.
- If_pc and if_inst are held while if_valid && !id_allowin.
- Next-PC priority (highest first): exc_flush → EXC_VEC; eret → epc; delivered instruction with br_pend, or with br_taken in the same cycle → br_pc / br_target; delivered instruction → fetch_pc+4 (mod 2^32, wraps).
- Delay slot:
  - br_taken sets br_pend=1 and br_pc=br_target; it does not discard the in-flight fetch, which is the delay slot.
  - br_pend clears when the next instruction is delivered.
- exc_flush / eret, in any state:
  - fetch_pc = target; if_valid=0; br_pend=0.
  - If in REQ or WAIT, set discard=1.
  - If in REQ, the request completes and its data is dropped.
- exc_flush and eret in the same cycle: exc_flush wins.
- exc_flush in the same cycle as inst_data_ok: the data is dropped, with no second discard.
- Latency: a minimum of 3 cycles from IDLE to if_valid (IDLE → REQ, addr_ok, data_ok with zero memory wait).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - perf_wait_cyc increments each cycle in REQ or WAIT.
  - perf_discard increments on each dropped response.
  - Both are 32-bit, saturating at 32'hffff_ffff, and cleared by rst.
- Undefined: both outputs tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package (cpu_defs_pkg) holds:
  - the FSM state typedef {IDLE, REQ, WAIT}
  - RESET_PC / EXC_VEC defaults
  - the 9-bit except code constants, including ADEL_IF = 9'b0_1000_0000.
- One natural sub-module, fetch_next_pc: combinational next-PC priority mux. The FSM, discard/br_pend flags and output registers stay in the top.

Test Plan:
- Reset release, memory with zero wait → inst_addr=32'h1fc0_0000; if_pc=32'hbfc0_0000 on the 3rd cycle; next fetch_pc=32'hbfc0_0004.
- Back-pressure: id_allowin=0 for 5 cycles with if_valid=1 → if_pc/if_inst held; no inst_req; resumes after allowin.
- br_taken (target 32'hbfc0_0100) while the delay slot at 32'hbfc0_0008 is in WAIT → slot delivered with if_pc=32'hbfc0_0008; next fetch_pc=32'hbfc0_0100.
- exc_flush in WAIT → data dropped, if_valid=0, next request to 32'h1fc0_0380; perf_discard=1 with the macro defined.
- det_ok=0 (fetch_pc=32'hbfc0_0002) → if_valid=1, if_inst=0, if_except=9'b0_1000_0000, no inst_req; then exc_flush → fetch resumes at EXC_VEC.
- eret and exc_flush in the same cycle, epc=32'h8000_0010 → fetch_pc=EXC_VEC.
